jpeg_rle_zrl: RTL
=================

Name: jpeg_rle_zrl

Overview:
- Run-length stage of the JPEG encoder pipeline (rle path, consumes the rle.rz* zero-run registers' domain).
- Takes 64 zig-zag-ordered quantized coefficients per 8x8 block and emits Huffman-ready tuples (run, size, amplitude).
- Inserts ZRL (15,0) symbols for runs of 16 zeros and terminates blocks with EOB.
- Sits between the quantizer/zig-zag output and the Huffman encoder, with valid/ready on both sides.

Parameters:
DW, 12, coefficient width (two's complement); also the out_amp width
SW, 4, width of out_size and out_run

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  coefficient valid
in_ready  out  1  stage can accept a coefficient this cycle
in_sob  in  1  start of block; qualifies in_coef as coefficient index 0 (DC)
in_coef  in  DW  quantized coefficient, signed
out_valid  out  1  output tuple valid
out_ready  in  1  downstream accepts the tuple
out_run  out  SW  zero-run preceding this symbol (0..15)
out_size  out  SW  magnitude category (0..DW)
out_amp  out  DW  amplitude bits, JPEG convention
out_dc  out  1  tuple is the DC coefficient
out_eob  out  1  tuple is EOB (run=0, size=0)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; idx=0, zc=0, pz=0; state RUN.
- Transfers: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready.
- Output register is single-entry. Tuple fields are stable while out_valid=1 && out_ready=0.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Latency: tuple appears on out_valid on the cycle after the input accept. The input accept loads the output register directly.
- Coefficient index idx (0..63):
  - in_sob=1 on accept forces idx=0 and clears zc and pz. A block abandoned mid-way emits nothing further (no EOB, no ZRL).
  - Otherwise idx increments per accept. After 63 it wraps to 0.
- Size and amplitude:
  - size = bit length of |v|. Examples: 0→0, ±1→1, ±2..3→2; -2048→12.
  - amp = v if v>=0, else (v-1) truncated to DW bits (low `size` bits are the one's complement).
- Per accepted coefficient v at idx k:
  - k==0: emit (0, size, amp) with out_dc=1. Zero DC emits size 0.
  - k in 1..63, v==0, k<63: zc++. If zc was 15, set zc=0 and pz++ (max 3). No output.
  - k in 1..63, v!=0, pz==0: emit (zc, size, amp); zc=0.
  - k in 1..63, v!=0, pz>0: latch the tuple and enter DRAIN.
    - DRAIN emits pz ZRL tuples (15,0,0), one per output fire.
    - After the ZRLs, emit the latched tuple, clear pz and zc, and return to RUN.
    - in_ready=0 throughout DRAIN.
  - k==63, v==0: discard pending pz and zc, emit EOB (out_eob=1, run 0, size 0, amp 0).
  - k==63, v!=0: emit the tuple only (after any ZRL drain); no EOB.
- State machine: RUN ↔ DRAIN only. DRAIN exits after the latched tuple fires.
- Back-pressure: out_ready=0 stalls everything; idx, zc and pz are unchanged while stalled.
- Maximum emitted per block: 1 DC + 63 tuples. pz never exceeds 3, since 62 zeros plus 1 nonzero is the worst case.
- Reset mid-DRAIN drops the latched tuple and all pending ZRLs.

Test Plan:
- Block DC=5, AC all zero, out_ready=1 → (0,3,5,dc); one cycle later EOB; exactly 2 tuples; in_ready=1 on all 64 cycles.
- DC=-3, AC1=0, AC2=1, rest 0 → (0,2,amp=0b00,dc), (1,1,1), EOB.
- DC=0, AC1..AC16=0, AC17=-1, rest 0 → (0,0,0,dc), (15,0,0), (0,1,0), EOB. in_ready=0 for exactly 1 cycle after the AC17 accept.
- DC=0, AC1..AC62=0, AC63=7 → DC tuple, 3×ZRL, (14,3,7); no EOB; in_ready low for 3 cycles.
- Trailing 40 zeros after AC23=2 → no ZRL emitted, single EOB. Hold out_ready=0 for 5 cycles mid-block → no tuple lost or duplicated, fields stable.
- Assert in_sob at idx 30 of a block with pz=1 → pending ZRL discarded and new DC tuple emitted. Drive rst low during DRAIN → out_valid=0 asynchronously; next block starts clean.

Source files
------------

// File: rtl/jpeg_rle_zrl.sv
// JPEG run-length stage: turns 64 zig-zag coefficients per block into
// (run, size, amplitude) tuples with ZRL insertion and EOB termination.
module jpeg_rle_zrl #(
  parameter int DW = 12,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sob,
  input  logic [DW-1:0] in_coef,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_run,
  output logic [SW-1:0] out_size,
  output logic [DW-1:0] out_amp,
  output logic          out_dc,
  output logic          out_eob
);

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [SW-1:0] run;
    logic [SW-1:0] size;
    logic [DW-1:0] amp;
    logic          dc;
    logic          eob;
  } tuple_t;

  localparam tuple_t ZRL_T = tuple_t'({{SW{1'b1}}, {SW{1'b0}}, {DW{1'b0}}, 2'b00});

  function automatic logic [SW-1:0] bit_len(input logic [DW:0] m);
    bit_len = '0;
    for (int i = 0; i <= DW; i++) begin
      if (m[i]) bit_len = SW'(i + 1);
    end
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [SW-1:0] zc_q, zc_d;
  logic [1:0]    pz_q, pz_d;
  logic          out_valid_q, out_valid_d;
  tuple_t        tup_q, tup_d;
  tuple_t        lat_q, lat_d;

  logic          out_free;
  logic          in_fire;
  logic          coef_zero;
  logic [5:0]    k;
  logic [SW-1:0] zc_base;
  logic [1:0]    pz_base;
  logic [DW:0]   mag;
  tuple_t        coef_t;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == RUN) && out_free;
  assign in_fire   = in_valid && in_ready;
  assign coef_zero = (in_coef == '0);
  // A start-of-block accept behaves as if idx, zc and pz were already cleared.
  assign k         = in_sob ? 6'd0 : idx_q;
  assign zc_base   = in_sob ? '0 : zc_q;
  assign pz_base   = in_sob ? 2'd0 : pz_q;
  assign mag       = in_coef[DW-1] ? ({1'b0, ~in_coef} + (DW+1)'(1)) : {1'b0, in_coef};

  always_comb begin
    coef_t      = '0;
    coef_t.run  = zc_base;
    coef_t.size = bit_len(mag);
    coef_t.amp  = in_coef[DW-1] ? (in_coef - DW'(1)) : in_coef;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zc_d        = zc_q;
    pz_d        = pz_q;
    tup_d       = tup_q;
    lat_d       = lat_q;
    out_valid_d = out_valid_q && !out_ready;

    if (in_fire) begin
      idx_d = k + 6'd1;
      if (k == 6'd0) begin
        tup_d       = coef_t;
        tup_d.run   = '0;
        tup_d.dc    = 1'b1;
        out_valid_d = 1'b1;
        zc_d        = '0;
        pz_d        = 2'd0;
      end else if (coef_zero && k != 6'd63) begin
        if (zc_base == {SW{1'b1}}) begin
          zc_d = '0;
          pz_d = (pz_base == 2'd3) ? pz_base : pz_base + 2'd1;
        end else begin
          zc_d = zc_base + SW'(1);
          pz_d = pz_base;
        end
      end else if (coef_zero) begin
        tup_d       = '0;
        tup_d.eob   = 1'b1;
        out_valid_d = 1'b1;
        zc_d        = '0;
        pz_d        = 2'd0;
      end else if (pz_base == 2'd0) begin
        tup_d       = coef_t;
        out_valid_d = 1'b1;
        zc_d        = '0;
        pz_d        = 2'd0;
      end else begin
        // First ZRL goes out immediately; pz counts the ones still to load.
        lat_d       = coef_t;
        tup_d       = ZRL_T;
        out_valid_d = 1'b1;
        pz_d        = pz_base - 2'd1;
        zc_d        = '0;
        state_d     = DRAIN;
      end
    end else if (state_q == DRAIN && out_free) begin
      out_valid_d = 1'b1;
      if (pz_q != 2'd0) begin
        tup_d = ZRL_T;
        pz_d  = pz_q - 2'd1;
      end else begin
        tup_d   = lat_q;
        zc_d    = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      idx_q       <= '0;
      zc_q        <= '0;
      pz_q        <= '0;
      out_valid_q <= 1'b0;
      tup_q       <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zc_q        <= zc_d;
      pz_q        <= pz_d;
      out_valid_q <= out_valid_d;
      tup_q       <= tup_d;
      lat_q       <= lat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_run   = tup_q.run;
  assign out_size  = tup_q.size;
  assign out_amp   = tup_q.amp;
  assign out_dc    = tup_q.dc;
  assign out_eob   = tup_q.eob;

endmodule
